// File: rtl/riscv.sv
// riscv: privilege-level and PMP configuration types shared with the CSR unit and PMP checkers
package riscv;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;
    typedef struct packed {
        logic       locked;
        logic [1:0] reserved;
        logic [1:0] addr_mode;
        logic [2:0] access_type;
    } pmpcfg_t;
endpackage

// File: rtl/pmp_csr_regfile.sv
// pmp_csr_regfile: machine-mode pmpcfg/pmpaddr storage with WARL and lock rules, 1-cycle CSR responses
module pmp_csr_regfile #(
    parameter int XLEN       = 32,
    parameter int PMP_LEN    = 32,
    parameter int NR_ENTRIES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          csr_req_i,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [XLEN-1:0]               csr_wdata_i,
    input  riscv::priv_lvl_t              priv_lvl_i,
    output logic                          csr_rvalid_o,
    output logic [XLEN-1:0]               csr_rdata_o,
    output logic                          csr_err_o,
    output logic [15:0][PMP_LEN-1:0]      conf_addr_o,
    output riscv::pmpcfg_t [15:0]         conf_o
);
    localparam int NB = XLEN / 8;
    localparam int KW = $clog2(NB);
    riscv::pmpcfg_t [15:0]    cfg_q, cfg_d;
    logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
    logic                     rvalid_q, err_q;
    logic [XLEN-1:0]          rdata_q, rdata_d;
    logic                     is_cfg, is_addr, legal, wr;
    logic [3:0]               cfg_base, addr_idx;
    logic [7:0]               wb;
    assign cfg_base = {csr_addr_i[1:0], 2'b00};
    assign addr_idx = csr_addr_i[3:0];
    assign is_cfg   = (csr_addr_i & 12'hFFC) == 12'h3A0;
    assign is_addr  = csr_addr_i[11:4] == 8'h3B;
    assign legal    = priv_lvl_i == riscv::PRIV_LVL_M &&
                      (is_addr || (is_cfg && !(XLEN == 64 && csr_addr_i[0])));
    assign wr       = csr_req_i && csr_we_i && legal;
    // Lock checks look only at pre-write state, so a write may set its own lock bit
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        wb     = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            wb = csr_wdata_i[(i % NB) * 8 +: 8];
            if (wr && is_cfg && (4'(i) >> KW) == (cfg_base >> KW) && !cfg_q[i].locked && !(!wb[0] && wb[1]))
                cfg_d[i] = {wb[7], 2'b00, wb[4:0]};
            if (wr && is_addr && addr_idx == 4'(i) && !cfg_q[i].locked &&
                !(i < 15 && cfg_q[(i + 1) % 16].locked && cfg_q[(i + 1) % 16].addr_mode == 2'b01))
                addr_d[i] = csr_wdata_i[PMP_LEN-1:0];
        end
    end
    always_comb begin
        rdata_d = '0;
        if (is_cfg)
            for (int k = 0; k < NB; k++)
                rdata_d[k*8 +: 8] = cfg_q[cfg_base + 4'(k)];
        if (is_addr)
            rdata_d = XLEN'(addr_q[addr_idx]);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q    <= '0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cfg_q    <= cfg_d;
            addr_q   <= addr_d;
            rvalid_q <= csr_req_i;
            err_q    <= csr_req_i && !legal;
            rdata_q  <= (csr_req_i && !csr_we_i && legal) ? rdata_d : '0;
        end
    end
    assign csr_rvalid_o = rvalid_q;
    assign csr_err_o    = err_q;
    assign csr_rdata_o  = rdata_q;
    assign conf_o       = cfg_q;
    assign conf_addr_o  = addr_q;
endmodule

// File: tb/tb_pmp_csr_regfile.sv
// tb_pmp_csr_regfile: table-driven scoreboard bench for a 32-bit/4-entry and a 64-bit/2-entry regfile
module tb_pmp_csr_regfile;
    localparam riscv::priv_lvl_t M = riscv::PRIV_LVL_M;
    localparam riscv::priv_lvl_t S = riscv::PRIV_LVL_S;
    localparam riscv::priv_lvl_t U = riscv::PRIV_LVL_U;

    typedef struct {
        logic             we;
        logic [11:0]      addr;
        logic [63:0]      wdata;
        riscv::priv_lvl_t priv;
        logic             err;
        logic [63:0]      rdata;
    } vec_t;
    typedef struct {
        int          due;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, req_a = 1'b0, req_b = 1'b0, we = 1'b0;
    logic [11:0] addr = '0;
    logic [63:0] wdata = '0;
    riscv::priv_lvl_t priv = riscv::PRIV_LVL_M;
    logic rvalid_a, err_a, rvalid_b, err_b;
    logic [31:0] rdata_a;
    logic [63:0] rdata_b;
    logic [15:0][31:0] caddr_a;
    logic [15:0][53:0] caddr_b;
    riscv::pmpcfg_t [15:0] conf_a, conf_b;

    vec_t tbl_a[$], tbl_b[$];
    exp_t qa[$], qb[$];
    int cyc = 0, errors = 0, checks = 0;

    pmp_csr_regfile #(.XLEN(32), .PMP_LEN(32), .NR_ENTRIES(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .csr_req_i(req_a), .csr_we_i(we), .csr_addr_i(addr),
        .csr_wdata_i(wdata[31:0]), .priv_lvl_i(priv), .csr_rvalid_o(rvalid_a),
        .csr_rdata_o(rdata_a), .csr_err_o(err_a), .conf_addr_o(caddr_a), .conf_o(conf_a));

    pmp_csr_regfile #(.XLEN(64), .PMP_LEN(54), .NR_ENTRIES(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .csr_req_i(req_b), .csr_we_i(we), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .priv_lvl_i(priv), .csr_rvalid_o(rvalid_b),
        .csr_rdata_o(rdata_b), .csr_err_o(err_b), .conf_addr_o(caddr_b), .conf_o(conf_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic b, input logic w, input logic [11:0] a, input logic [63:0] d,
                                input riscv::priv_lvl_t p, input logic e, input logic [63:0] r);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.priv = p; v.err = e; v.rdata = r;
        if (b) tbl_b.push_back(v);
        else tbl_a.push_back(v);
    endfunction

    task automatic issue(input logic b, input vec_t v);
        exp_t x;
        @(posedge clk); #1;
        req_a = !b; req_b = b; we = v.we; addr = v.addr; wdata = v.wdata; priv = v.priv;
        x.due = cyc + 1; x.err = v.err; x.rdata = v.rdata;
        if (b) qb.push_back(x);
        else qa.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_a = 1'b0; req_b = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a) begin
            if (qa.size() == 0 || qa[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL a_unexpected_rvalid: got rvalid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = qa.pop_front();
                check("a_err", {63'b0, err_a}, {63'b0, e.err});
                check("a_rdata", {32'b0, rdata_a}, e.rdata);
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            checks++; errors++;
            $display("FAIL a_missing_rvalid: got rvalid=0 expected 1 at cycle %0d", cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_b) begin
            if (qb.size() == 0 || qb[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL b_unexpected_rvalid: got rvalid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = qb.pop_front();
                check("b_err", {63'b0, err_b}, {63'b0, e.err});
                check("b_rdata", rdata_b, e.rdata);
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            checks++; errors++;
            $display("FAIL b_missing_rvalid: got rvalid=0 expected 1 at cycle %0d", cyc);
        end
    end

    initial begin
        vec_t v;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", {63'b0, rvalid_a}, 64'h0);
        check("reset_err", {63'b0, err_a}, 64'h0);
        check("reset_rdata", {32'b0, rdata_a}, 64'h0);
        check("reset_conf", {63'b0, conf_a != '0}, 64'h0);
        check("reset_conf_addr", {63'b0, caddr_a != '0}, 64'h0);
        rst = 1'b0;

        add(0, 0, 12'h3A0, 0, M, 0, 0);
        add(0, 0, 12'h3B0, 0, M, 0, 0);
        add(0, 1, 12'h3A0, 64'h0F0B, M, 0, 0);
        add(0, 0, 12'h3A0, 0, M, 0, 64'h0F0B);
        add(0, 1, 12'h3A0, 64'h6F02, M, 0, 0);
        add(0, 0, 12'h3A0, 0, M, 0, 64'h0F0B);
        add(0, 0, 12'h3B0, 0, S, 1, 0);
        add(0, 1, 12'h3C0, 64'hFFFF, M, 1, 0);
        add(0, 0, 12'h3A0, 0, M, 0, 64'h0F0B);
        add(0, 1, 12'h3B2, 64'hFFFF_FFFF, M, 0, 0);
        add(0, 0, 12'h3B2, 0, M, 0, 64'hFFFF_FFFF);
        add(0, 1, 12'h3B0, 64'h1111, M, 0, 0);
        add(0, 0, 12'h3B0, 0, M, 0, 64'h1111);
        add(0, 1, 12'h3A0, 64'h880B, M, 0, 0);
        add(0, 1, 12'h3B0, 64'h1234, M, 0, 0);
        add(0, 1, 12'h3B1, 64'h5678, M, 0, 0);
        add(0, 0, 12'h3B0, 0, M, 0, 64'h1111);
        add(0, 0, 12'h3B1, 0, M, 0, 0);
        add(0, 1, 12'h3A0, 64'h000F, M, 0, 0);
        add(0, 0, 12'h3A0, 0, M, 0, 64'h880F);
        add(0, 1, 12'h3A4, 64'h1, M, 1, 0);
        add(0, 1, 12'h3A1, 64'hFFFF_FFFF, M, 0, 0);
        add(0, 0, 12'h3A1, 0, M, 0, 0);
        add(0, 0, 12'h3A3, 0, M, 0, 0);
        add(0, 1, 12'h3B5, 64'hABCD, M, 0, 0);
        add(0, 0, 12'h3B5, 0, M, 0, 0);
        add(0, 0, 12'h3B0, 0, U, 1, 0);

        add(1, 1, 12'h3B2, 64'hFFFF_FFFF, M, 0, 0);
        add(1, 0, 12'h3B2, 0, M, 0, 0);
        add(1, 1, 12'h3B1, 64'hFFFF_FFFF_FFFF_FFFF, M, 0, 0);
        add(1, 0, 12'h3B1, 0, M, 0, 64'h003F_FFFF_FFFF_FFFF);
        add(1, 0, 12'h3A1, 0, M, 1, 0);
        add(1, 1, 12'h3A0, 64'h0F0B, M, 0, 0);
        add(1, 0, 12'h3A0, 0, M, 0, 64'h0F0B);
        add(1, 1, 12'h3A2, 64'hFF, M, 0, 0);
        add(1, 0, 12'h3A2, 0, M, 0, 0);
        add(1, 1, 12'h3A3, 64'h1, M, 1, 0);

        foreach (tbl_a[i]) issue(0, tbl_a[i]);
        idle(2);
        check("conf_entry0", 64'(conf_a[0]), 64'h0F);
        check("conf_entry1_locked", 64'(conf_a[1]), 64'h88);
        check("conf_addr0", 64'(caddr_a[0]), 64'h1111);
        check("conf_addr2", 64'(caddr_a[2]), 64'hFFFF_FFFF);
        foreach (tbl_b[i]) issue(1, tbl_b[i]);
        idle(2);
        check("b_conf_addr1", 64'(caddr_b[1]), 64'h003F_FFFF_FFFF_FFFF);
        check("b_conf_addr2", 64'(caddr_b[2]), 64'h0);

        @(posedge clk); #1;
        req_a = 1'b1; we = 1'b1; addr = 12'h3B3; wdata = 64'hAAAA; priv = M; rst = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; rst = 1'b0;
        check("drop_rvalid", {63'b0, rvalid_a}, 64'h0);
        check("drop_conf", {63'b0, conf_a != '0}, 64'h0);
        check("drop_conf_addr", {63'b0, caddr_a != '0}, 64'h0);
        v.we = 0; v.addr = 12'h3A0; v.wdata = 0; v.priv = M; v.err = 0; v.rdata = 0;
        issue(0, v);
        v.addr = 12'h3B3;
        issue(0, v);
        v.we = 1; v.addr = 12'h3B0; v.wdata = 64'h1234;
        issue(0, v);
        v.we = 0; v.wdata = 0; v.rdata = 64'h1234;
        issue(0, v);
        idle(3);
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending responses expected 0", qa.size(), qb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
